wb_gpio_regbank: RTL

// - Parametrised Wishbone-classic slave exposing NUM_GPIO breakout pins (1..64) as memory-mapped registers.
// - Registers: output data, active-low output enable, synchronised input, per-pin edge IRQ.
// - Sits between the Caravel user-area Wishbone slave port and gpio_in/out/oeb.
// - Programmable wait states; sticky W1C interrupt status; single combined IRQ line.

---
 rtl/wb_gpio_regbank.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/wb_gpio_regbank.sv
// Wishbone-classic GPIO register bank: output data, active-low output enable,
// synchronised inputs and per-pin edge interrupts, with programmable wait states.
module wb_gpio_regbank #(
    parameter int unsigned NUM_GPIO    = 34,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                wb_clk_i,
    input  logic                nrst,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    input  logic [NUM_GPIO-1:0] gpio_in,
    output logic [NUM_GPIO-1:0] gpio_out,
    output logic [NUM_GPIO-1:0] gpio_oeb,
    output logic                irq_o
);
    localparam int unsigned WW = ADDR_W - 2;
    localparam logic [63:0] PIN_MASK = (NUM_GPIO >= 64) ? {64{1'b1}}
                                                        : ((64'd1 << NUM_GPIO) - 64'd1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                ack_q, ack_d;
    logic [31:0]         dat_q, dat_d;
    logic [WW-1:0]       idx_q;
    logic [31:0]         wdat_q;
    logic [3:0]          sel_q;
    logic                we_q;
    logic                capture, commit;

    logic [63:0]         out_q, oeb_q, en_q, stat_q, pol_q;
    logic [63:0]         out_d, oeb_d, en_d, stat_d, pol_d, clr;
    logic [NUM_GPIO-1:0] sync1_q, sync2_q, prev_q;
    logic [1:0]          arm_q;

    logic                hit, in_range;
    logic [63:0]         wr_mask, wr_data, rd_reg, edge_set;
    logic [31:0]         lane_mask, rd_data;
    logic [NUM_GPIO-1:0] edge_hit;
    logic                unused_adr;

    assign unused_adr = ^wbs_adr_i[1:0];
    assign hit        = (wbs_adr_i[31:ADDR_W] == BASE_ADDR[31:ADDR_W]);
    assign in_range   = (idx_q < WW'(12));

    assign lane_mask = {{8{sel_q[3]}}, {8{sel_q[2]}}, {8{sel_q[1]}}, {8{sel_q[0]}}};
    assign wr_mask   = idx_q[0] ? {lane_mask, 32'd0} : {32'd0, lane_mask};
    assign wr_data   = {wdat_q, wdat_q};

    // Edge polarity per pin; nothing is reported until the synchroniser has settled
    assign edge_hit = (pol_q[NUM_GPIO-1:0] & ~sync2_q & prev_q)
                    | (~pol_q[NUM_GPIO-1:0] & sync2_q & ~prev_q);
    assign edge_set = (arm_q == 2'd3) ? 64'(edge_hit) : 64'd0;

    always_comb begin
        rd_reg = 64'd0;
        if (in_range) begin
            case (idx_q[3:1])
                3'd0:    rd_reg = out_q;
                3'd1:    rd_reg = oeb_q;
                3'd2:    rd_reg = 64'(sync2_q);
                3'd3:    rd_reg = en_q;
                3'd4:    rd_reg = stat_q;
                3'd5:    rd_reg = pol_q;
                default: rd_reg = 64'd0;
            endcase
        end
    end
    assign rd_data = idx_q[0] ? rd_reg[63:32] : rd_reg[31:0];

    function automatic logic [63:0] merge(input logic [63:0] cur, input logic [63:0] d,
                                          input logic [63:0] m);
        return ((cur & ~m) | (d & m)) & PIN_MASK;
    endfunction

    // Bus FSM and register next-state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        dat_d   = 32'd0;
        capture = 1'b0;
        commit  = 1'b0;
        out_d   = out_q;
        oeb_d   = oeb_q;
        en_d    = en_q;
        pol_d   = pol_q;
        clr     = 64'd0;
        case (state_q)
            S_IDLE: begin
                if (wbs_cyc_i && wbs_stb_i && hit) begin
                    capture = 1'b1;
                    cnt_d   = 3'd0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!wbs_cyc_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 3'(WAIT_STATES)) begin
                    state_d = S_ACK;
                    ack_d   = 1'b1;
                    dat_d   = we_q ? 32'd0 : rd_data;
                    commit  = we_q;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (commit && in_range) begin
            case (idx_q[3:1])
                3'd0:    out_d = merge(out_q, wr_data, wr_mask);
                3'd1:    oeb_d = merge(oeb_q, wr_data, wr_mask);
                3'd3:    en_d  = merge(en_q, wr_data, wr_mask);
                3'd4:    clr   = wr_data & wr_mask;
                3'd5:    pol_d = merge(pol_q, wr_data, wr_mask);
                default: ;
            endcase
        end
        // A fresh edge beats a simultaneous write-one-to-clear
        stat_d = ((stat_q & ~clr) | edge_set) & PIN_MASK;
    end

    always_ff @(posedge wb_clk_i) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            ack_q   <= 1'b0;
            dat_q   <= 32'd0;
            idx_q   <= '0;
            wdat_q  <= 32'd0;
            sel_q   <= 4'd0;
            we_q    <= 1'b0;
            out_q   <= 64'd0;
            oeb_q   <= PIN_MASK;
            en_q    <= 64'd0;
            stat_q  <= 64'd0;
            pol_q   <= 64'd0;
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            arm_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            if (capture) begin
                idx_q  <= wbs_adr_i[ADDR_W-1:2];
                wdat_q <= wbs_dat_i;
                sel_q  <= wbs_sel_i;
                we_q   <= wbs_we_i;
            end
            out_q   <= out_d;
            oeb_q   <= oeb_d;
            en_q    <= en_d;
            stat_q  <= stat_d;
            pol_q   <= pol_d;
            sync1_q <= gpio_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (arm_q != 2'd3) arm_q <= arm_q + 2'd1;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign gpio_out  = out_q[NUM_GPIO-1:0];
    assign gpio_oeb  = oeb_q[NUM_GPIO-1:0];
    assign irq_o     = |(stat_q & en_q);

endmodule
